// File: rtl/seq_run_ctrl_pkg.sv
// seq_run_ctrl_pkg: controller states, run modes and the leg-reload rule
package seq_run_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;
  typedef enum logic [1:0] {MODE_ONCE, MODE_PINGPONG, MODE_LOOP, MODE_RSVD} mode_t;
  function automatic logic leg_reloads(input mode_t mode, input logic second_leg);
    return mode == MODE_LOOP || (mode == MODE_PINGPONG && !second_leg);
  endfunction
endpackage

// File: rtl/seq_run_ctrl_step_timer.sv
// seq_run_ctrl_step_timer: rate prescaler plus per-leg step down-counter with load/freeze
module seq_run_ctrl_step_timer #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] ld_steps,
  input  logic [DIV_W-1:0] ld_div,
  output logic             tick,
  output logic             leg_end,
  output logic [CNT_W-1:0] steps_left
);
  logic [DIV_W-1:0] pre;
  assign tick = run && pre == '0 && steps_left != '0;
  assign leg_end = tick && steps_left == CNT_W'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pre <= '0;
      steps_left <= '0;
    end else if (clr) begin
      pre <= '0;
      steps_left <= '0;
    end else if (load) begin
      pre <= ld_div;
      steps_left <= ld_steps;
    end else if (tick) begin
      pre <= ld_div;
      steps_left <= steps_left - CNT_W'(1);
    end else if (run && pre != '0) begin
      pre <= pre - DIV_W'(1);
    end
endmodule

// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl: paces enable/up_down pulses to the up/down sequence generator over a commanded run
module seq_run_ctrl
  import seq_run_ctrl_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] div,
  output logic             enable,
  output logic             up_down,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);
  state_t state, state_nxt;
  mode_t mode_q;
  logic [CNT_W-1:0] steps_q, ld_steps;
  logic [DIV_W-1:0] div_q, ld_div;
  logic second_leg, flip_q, t_load, t_run, tick, leg_end;
  assign ld_steps = state == S_IDLE ? steps : steps_q;
  assign ld_div = state == S_IDLE ? div : div_q;
  // a pending flip spends one pulse-free cycle turning up_down and reloading the leg
  assign t_load = !abort && (state == S_IDLE ? start : state == S_RUN && flip_q);
  assign t_run = !abort && state == S_RUN && !pause && !flip_q;
  seq_run_ctrl_step_timer #(.CNT_W(CNT_W), .DIV_W(DIV_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(abort),
    .load(t_load),
    .run(t_run),
    .ld_steps(ld_steps),
    .ld_div(ld_div),
    .tick(tick),
    .leg_end(leg_end),
    .steps_left(steps_left)
  );
  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = S_IDLE;
    else
      case (state)
        S_IDLE: state_nxt = !start ? S_IDLE : steps == '0 ? S_DONE : S_RUN;
        S_RUN: state_nxt = pause ? S_HOLD : leg_end && !leg_reloads(mode_q, second_leg) ? S_DONE : S_RUN;
        S_HOLD: state_nxt = pause ? S_HOLD : S_RUN;
        default: state_nxt = S_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      mode_q <= MODE_ONCE;
      steps_q <= '0;
      div_q <= '0;
      second_leg <= 1'b0;
      flip_q <= 1'b0;
      enable <= 1'b0;
      up_down <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      enable <= tick;
      busy <= state_nxt != S_IDLE;
      done <= state == S_DONE && !abort;
      if (t_load && state == S_IDLE) begin
        mode_q <= mode_t'(mode);
        steps_q <= steps;
        div_q <= div;
        up_down <= dir;
        second_leg <= 1'b0;
        flip_q <= 1'b0;
      end
      if (t_load && state == S_RUN) begin
        up_down <= !up_down;
        flip_q <= 1'b0;
      end
      if (leg_end && leg_reloads(mode_q, second_leg)) begin
        flip_q <= 1'b1;
        second_leg <= 1'b1;
      end
    end
endmodule
